// File: rtl/rom_loader.sv
// ROM download loader: splits a framed byte stream into SDRAM words,
// BRAM bytes and a board configuration byte.
module rom_loader #(
  parameter int SDR_AW  = 25,
  parameter int BRAM_AW = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ioctl_download,
  input  logic               ioctl_wr,
  input  logic [7:0]         ioctl_data,
  output logic               ioctl_wait,
  output logic [SDR_AW-1:0]  sdr_addr,
  output logic [15:0]        sdr_data,
  output logic               sdr_req,
  input  logic               sdr_ack,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic [7:0]         bram_data,
  output logic [1:0]         bram_cs,
  output logic               bram_wr,
  output logic [7:0]         board_cfg,
  output logic               load_done,
  output logic               load_err
);

  typedef enum logic [2:0] {
    IDLE, LEN, DATA, SDR_WAIT, CFG, DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 dl_q;
  logic [2:0]           region_q, region_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [31:0]          len_q, len_d;
  logic [SDR_AW-1:0]    off_q, off_d;
  logic [SDR_AW-1:0]    sdr_addr_q, sdr_addr_d;
  logic [15:0]          sdr_data_q, sdr_data_d;
  logic                 sdr_req_q, sdr_req_d;
  logic [BRAM_AW-1:0]   bram_addr_q, bram_addr_d;
  logic [7:0]           bram_data_q, bram_data_d;
  logic [1:0]           bram_cs_q, bram_cs_d;
  logic                 bram_wr_q, bram_wr_d;
  logic [7:0]           cfg_q, cfg_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 rise, fall, acc, last, at_end, is_bram;
  logic                 adv, issue;
  logic [SDR_AW-1:0]    off_inc, base, woff;

  assign ioctl_wait = (state_q == SDR_WAIT);
  assign sdr_addr   = sdr_addr_q;
  assign sdr_data   = sdr_data_q;
  assign sdr_req    = sdr_req_q;
  assign bram_addr  = bram_addr_q;
  assign bram_data  = bram_data_q;
  assign bram_cs    = bram_cs_q;
  assign bram_wr    = bram_wr_q;
  assign board_cfg  = cfg_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

  assign rise    = ioctl_download & ~dl_q;
  assign fall    = ~ioctl_download & dl_q;
  assign acc     = ioctl_wr & ~ioctl_wait;
  assign off_inc = off_q + 1'b1;
  assign last    = (32'(off_inc) == len_q);
  assign at_end  = (32'(off_q) == len_q);
  assign is_bram = (region_q >= 3'd4);

  // Region base address and word offset, with sprite bit swizzle
  always_comb begin
    base = '0;
    woff = {off_q[SDR_AW-1:1], 1'b0};
    unique case (region_q)
      3'd1: begin
        base = SDR_AW'(32'h100000);
        woff = {off_q[SDR_AW-1:6], off_q[4:1], off_q[5], 1'b0};
      end
      3'd2:    base = SDR_AW'(32'h200000);
      3'd3:    base = SDR_AW'(32'h300000);
      default: base = '0;
    endcase
  end

  // Next-state and output logic for the stream parser
  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    off_d       = off_q;
    sdr_addr_d  = sdr_addr_q;
    sdr_data_d  = sdr_data_q;
    sdr_req_d   = sdr_req_q & ~sdr_ack;
    bram_addr_d = bram_addr_q;
    bram_data_d = bram_data_q;
    bram_cs_d   = bram_cs_q;
    bram_wr_d   = 1'b0;
    cfg_d       = cfg_q;
    done_d      = done_q;
    err_d       = err_q;
    adv         = 1'b0;
    issue       = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (rise) begin
          state_d  = LEN;
          region_d = '0;
          cnt_d    = '0;
          len_d    = '0;
          off_d    = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
        end
      end
      LEN: begin
        if (acc) begin
          len_d = {len_q[23:0], ioctl_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            off_d = '0;
            if ({len_q[23:0], ioctl_data} == 32'd0) adv = 1'b1;
            else state_d = DATA;
          end
        end
      end
      DATA: begin
        if (acc) begin
          off_d = off_inc;
          if (is_bram) begin
            bram_wr_d   = 1'b1;
            bram_addr_d = off_q[BRAM_AW-1:0];
            bram_data_d = ioctl_data;
            bram_cs_d   = (region_q == 3'd5) ? 2'b10 : 2'b01;
            adv         = last;
          end else if (!off_q[0]) begin
            sdr_data_d[7:0] = ioctl_data;
            if (last) begin
              sdr_data_d[15:8] = 8'h00;
              issue = 1'b1;
            end
          end else begin
            sdr_data_d[15:8] = ioctl_data;
            issue = 1'b1;
          end
        end
      end
      SDR_WAIT: begin
        if (sdr_req_q && sdr_ack) begin
          if (at_end) adv = 1'b1;
          else state_d = DATA;
        end
      end
      CFG: begin
        if (acc) begin
          cfg_d   = ioctl_data;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      sdr_addr_d = base + woff;
      sdr_req_d  = 1'b1;
      state_d    = SDR_WAIT;
    end
    if (adv) begin
      cnt_d = '0;
      len_d = '0;
      off_d = '0;
      if (region_q == 3'd5) begin
        state_d = CFG;
      end else begin
        region_d = region_q + 3'd1;
        state_d  = LEN;
      end
    end
    if (fall && (state_q == LEN || state_q == DATA ||
                 state_q == SDR_WAIT)) begin
      state_d   = IDLE;
      err_d     = 1'b1;
      sdr_req_d = sdr_req_q & ~sdr_ack;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dl_q        <= 1'b0;
      region_q    <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      off_q       <= '0;
      sdr_addr_q  <= '0;
      sdr_data_q  <= '0;
      sdr_req_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
      bram_cs_q   <= '0;
      bram_wr_q   <= 1'b0;
      cfg_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_q        <= ioctl_download;
      region_q    <= region_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      off_q       <= off_d;
      sdr_addr_q  <= sdr_addr_d;
      sdr_data_q  <= sdr_data_d;
      sdr_req_q   <= sdr_req_d;
      bram_addr_q <= bram_addr_d;
      bram_data_q <= bram_data_d;
      bram_cs_q   <= bram_cs_d;
      bram_wr_q   <= bram_wr_d;
      cfg_q       <= cfg_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter SDR_AW, default 25, SDRAM byte-address width.
REQ-002 SHALL have parameter BRAM_AW, default 20, BRAM byte-address width.
REQ-003 SHALL have ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  download session active
- ioctl_wr  in  1  byte strobe, one byte per high cycle
- ioctl_data  in  8  download byte
- ioctl_wait  out  1  stall request to byte source
- sdr_addr  out  SDR_AW  SDRAM byte address, even
- sdr_data  out  16  SDRAM write word
- sdr_req  out  1  SDRAM write request
- sdr_ack  in  1  SDRAM write accepted
- bram_addr  out  BRAM_AW  BRAM byte address
- bram_data  out  8  BRAM write byte
- bram_cs  out  2  BRAM select, 01 MCU, 10 samples
- bram_wr  out  1  BRAM write strobe
- board_cfg  out  8  {reserved[3:0], main_mculatch, memory_map[2:0]}
- load_done  out  1  stream complete, cfg valid
- load_err  out  1  session ended early

Function
REQ-004 Stream format: six region records in fixed order CPU_ROM, SPRITE, BG_A, BG_B, MCU, SAMPLES; each = 4-byte big-endian length L then L data bytes; then one board_cfg byte.
REQ-005 Region table: CPU_ROM 0x000000/no reorder/SDRAM; SPRITE 0x100000/reorder/SDRAM; BG_A 0x200000; BG_B 0x300000; MCU BRAM cs 01 base 0; SAMPLES BRAM cs 10 base 0.
REQ-006 States: IDLE, LEN, DATA, SDR_WAIT, CFG, DONE.
REQ-007 IDLE->LEN on ioctl_download rising edge; region index=0, byte offset o=0, length shift register cleared, load_done=0, load_err=0.
REQ-008 LEN: each accepted byte shifts into length; after 4th byte, L==0 advances region (no DATA); else ->DATA.
REQ-009 SDRAM regions: even-o byte latched into sdr_data[7:0]; odd-o byte into [15:8], then sdr_req=1 next cycle, state SDR_WAIT.
REQ-010 SDRAM address = base + d, d = o when reorder=0; reorder=1: d = {o[24:6], o[4:1], o[5], o[0]} with bit 0 forced 0.
REQ-011 sdr_req and sdr_addr/sdr_data SHALL hold stable until sdr_ack sampled high; sdr_req low the cycle after ack; ack while sdr_req=0 ignored.
REQ-012 ioctl_wait SHALL be 1 whenever state is SDR_WAIT; ioctl_wr while ioctl_wait=1 is ignored.
REQ-013 Odd L: final byte written with sdr_data[15:8]=0x00.
REQ-014 BRAM regions: each accepted byte produces bram_wr=1 for exactly one cycle next cycle, bram_addr=o, bram_data=byte, bram_cs per region; no stall.
REQ-015 o increments per data byte; region ends when o==L (after flush of any pending SDRAM word); next region ->LEN; after SAMPLES ->CFG.
REQ-016 CFG: next accepted byte -> board_cfg, load_done=1 same cycle, ->DONE.
REQ-017 DONE holds outputs; new ioctl_download rising -> REQ-007 (board_cfg retained until overwritten).
REQ-018 ioctl_download falling while not in CFG/DONE: abort, load_err=1, ->IDLE, sdr_req dropped only after pending ack.
REQ-019 Lengths wrap mod 2^32; o width SDR_AW; L beyond region range is not checked.

Reset
REQ-020 reset_n low SHALL asynchronously force IDLE, all outputs 0 (board_cfg=0x00), counters 0; reset mid-write abandons request.
REQ-021 Post-reset, first action requires an ioctl_download rising edge.

Verification
REQ-022 CPU_ROM L=4 bytes 11 22 33 44, others L=0, cfg 0x13 -> writes (0x000000,0x2211),(0x000002,0x4433); board_cfg=0x13; load_done=1.
REQ-023 SPRITE L=64, byte k=k -> byte 0x20,0x21 word at 0x100002; byte 0x02,0x03 at 0x100004.
REQ-024 sdr_ack delayed 5 cycles -> ioctl_wait high 5+ cycles, sdr_req/address stable, no lost bytes.
REQ-025 MCU L=3 A,B,C -> three bram_wr pulses, cs=01, addr 0,1,2; SAMPLES L=1 -> cs=10 addr 0.
REQ-026 BG_A L=3 -> second word 0x00XX at 0x200002.
REQ-027 ioctl_download drops mid-BG_B -> load_err=1, IDLE; reset_n low mid-SDR_WAIT -> sdr_req=0 immediately.
